stim_stream_buffer: RTL and testbench

- Parametrised, synthesizable sample buffer between a stimulus source and a DUT input stream.
- The source is a DPI/Python feed in simulation or an upstream block in hardware.
- Accepts signed samples tagged with a channel over valid/ready, stamps each accepted sample with a wrapping sequence number, and stores it in a circular FIFO of DEPTH entries.
- Presents samples first-word-fall-through to the consumer; selectable full policy is backpressure or drop-oldest (sliding window of the last DEPTH samples).

---
 rtl/stim_stream_buffer_if.sv | 45 ++++
 rtl/stim_stream_buffer.sv | 170 +++++++++++++++++
 tb/tb_stim_stream_buffer.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stim_stream_buffer_if.sv
// ---------------------------------------------------------------------------
// stim_stream_buffer_if
//   Bundles the two valid/ready streams of stim_stream_buffer: the inbound
//   sample stream from the stimulus source and the outbound stream toward
//   the consumer.
//
//   Signals:
//     in_valid / in_ready  inbound handshake
//     in_data              signed sample (DATA_W)
//     in_chan              channel tag (CH_W)
//     out_valid / out_ready outbound handshake
//     out_data             head sample (DATA_W)
//     out_chan             head channel tag (CH_W)
//     out_seq              sequence number stamped on the head (CNT_W)
//
//   Modports:
//     slave  - the buffer itself (sinks in_*, sources out_*)
//     master - the environment (sources in_*, sinks out_*)
// ---------------------------------------------------------------------------
interface stim_stream_buffer_if #(
  parameter int DATA_W = 17,
  parameter int CH_W   = 1,
  parameter int CNT_W  = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic [CH_W-1:0]          in_chan;

  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic [CH_W-1:0]          out_chan;
  logic [CNT_W-1:0]         out_seq;

  modport slave (
    input  in_valid, in_data, in_chan, out_ready,
    output in_ready, out_valid, out_data, out_chan, out_seq
  );

  modport master (
    output in_valid, in_data, in_chan, out_ready,
    input  in_ready, out_valid, out_data, out_chan, out_seq
  );
endinterface

// File: rtl/stim_stream_buffer.sv
// ---------------------------------------------------------------------------
// stim_stream_buffer
//   Circular FIFO between a stimulus source and a consumer. Each accepted
//   sample is stamped with a wrapping sequence number and presented
//   first-word-fall-through. When full, the buffer either back-pressures
//   the source (DROP_OLDEST=0) or discards its oldest entry to keep a
//   sliding window of the last DEPTH samples (DROP_OLDEST=1).
//
//   Ports:
//     clk       rising-edge clock
//     rst       synchronous active-high reset (overrides everything)
//     clear     synchronous flush of contents; counters and flags kept
//     bus       inbound/outbound streams (stim_stream_buffer_if.slave)
//     level     occupancy, 0..DEPTH
//     full      level == DEPTH
//     empty     level == 0
//     drop_cnt  saturating count of discarded samples
//     bad_chan  sticky flag: a sample tagged with in_chan >= CHANNELS arrived
// ---------------------------------------------------------------------------
module stim_stream_buffer #(
  parameter int DATA_W      = 17,
  parameter int DEPTH       = 128,
  parameter int CHANNELS    = 1,
  parameter int DROP_OLDEST = 0,
  parameter int CNT_W       = 16,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int AW         = $clog2(DEPTH),
  localparam int LVL_W      = AW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  stim_stream_buffer_if.slave  bus,
  output logic [LVL_W-1:0]     level,
  output logic                 full,
  output logic                 empty,
  output logic [CNT_W-1:0]     drop_cnt,
  output logic                 bad_chan
);

  typedef struct packed {
    logic signed [DATA_W-1:0] data;
    logic [CH_W-1:0]          chan;
    logic [CNT_W-1:0]         seq;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           wdata;
  entry_t           head;

  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] seq_q, seq_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             bad_q, bad_d;

  logic             accept;     // handshake completed on the inbound side
  logic             chan_bad;   // tag outside 0..CHANNELS-1
  logic             push;       // accepted sample actually stored
  logic             pop;        // head consumed
  logic             drop;       // oldest entry overwritten by a push while full

  // -------------------------------------------------------------------------
  // Status and handshake
  // -------------------------------------------------------------------------
  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;

  // Ready is a function of registered state only, so a pop in the same cycle
  // never opens the door for a push in backpressure mode.
  assign bus.in_ready  = !rst && ((DROP_OLDEST != 0) ? 1'b1 : !full);
  assign bus.out_valid = !empty;

  assign accept   = bus.in_valid && bus.in_ready;
  assign chan_bad = (int'(bus.in_chan) >= CHANNELS);
  assign push     = accept && !chan_bad && !clear;
  assign pop      = bus.out_valid && bus.out_ready && !clear;
  // Only reachable in drop-oldest mode: in backpressure mode in_ready is low
  // whenever full is high.
  assign drop     = push && full && !pop;

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  assign wdata = '{data: bus.in_data, chan: bus.in_chan, seq: seq_q};

  // NOTE: the memory array has no reset; pointers and level define which
  // entries are live, so clearing the payload would only cost logic.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_q] <= wdata;
    end
  end

  // Head is read combinationally from the registered read pointer and forced
  // to zero while empty so stale or uninitialised payload never shows.
  assign head         = mem_q[rd_q];
  assign bus.out_data = empty ? '0 : head.data;
  assign bus.out_chan = empty ? '0 : head.chan;
  assign bus.out_seq  = empty ? '0 : head.seq;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every variable gets its hold value first so no path through the
  // block leaves it unassigned, which would infer a latch.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    seq_d   = seq_q;
    drop_d  = drop_q;
    bad_d   = bad_q;

    if (accept && chan_bad) begin
      bad_d = 1'b1;
    end

    if (clear) begin
      wr_d    = '0;
      rd_d    = '0;
      level_d = '0;
    end else begin
      if (push) begin
        wr_d  = wr_q + 1'b1;
        seq_d = seq_q + 1'b1;
      end
      if (pop || drop) begin
        rd_d = rd_q + 1'b1;
      end
      if (push && !pop && !drop) begin
        level_d = level_q + 1'b1;
      end else if (pop && !push) begin
        level_d = level_q - 1'b1;
      end
      if (drop && (drop_q != {CNT_W{1'b1}})) begin
        drop_d = drop_q + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      seq_q   <= '0;
      drop_q  <= '0;
      bad_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      seq_q   <= seq_d;
      drop_q  <= drop_d;
      bad_q   <= bad_d;
    end
  end

  assign drop_cnt = drop_q;
  assign bad_chan = bad_q;

endmodule

// File: tb/tb_stim_stream_buffer.sv
// ---------------------------------------------------------------------------
// tb_stim_stream_buffer
//   Three buffer instances share one stimulus bus; sel routes the handshake
//   to one of them and muxes its outputs back for checking:
//     A: DEPTH=8, CHANNELS=3, backpressure, CNT_W=16
//     B: DEPTH=4, CHANNELS=1, backpressure, CNT_W=16
//     C: DEPTH=4, CHANNELS=1, drop-oldest,  CNT_W=4
// ---------------------------------------------------------------------------
module tb_stim_stream_buffer;
  localparam int DW = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, clear, in_valid, out_ready;
  logic signed [DW-1:0] in_data;
  logic [1:0]           in_chan;
  logic [1:0]           sel;

  int n_tests = 0;
  int n_fail  = 0;

  stim_stream_buffer_if #(.DATA_W(DW), .CH_W(2), .CNT_W(16)) if_a ();
  stim_stream_buffer_if #(.DATA_W(DW), .CH_W(1), .CNT_W(16)) if_b ();
  stim_stream_buffer_if #(.DATA_W(DW), .CH_W(1), .CNT_W(4))  if_c ();

  logic [3:0]  lvl_a;
  logic [2:0]  lvl_b, lvl_c;
  logic        full_a, full_b, full_c, empty_a, empty_b, empty_c;
  logic        bad_a, bad_b, bad_c;
  logic [15:0] drop_a, drop_b;
  logic [3:0]  drop_c;

  assign if_a.in_valid  = in_valid && (sel == 2'd0);
  assign if_b.in_valid  = in_valid && (sel == 2'd1);
  assign if_c.in_valid  = in_valid && (sel == 2'd2);
  assign if_a.out_ready = out_ready && (sel == 2'd0);
  assign if_b.out_ready = out_ready && (sel == 2'd1);
  assign if_c.out_ready = out_ready && (sel == 2'd2);
  assign if_a.in_data   = in_data;
  assign if_b.in_data   = in_data;
  assign if_c.in_data   = in_data;
  assign if_a.in_chan   = in_chan;
  assign if_b.in_chan   = 1'b0;
  assign if_c.in_chan   = 1'b0;

  stim_stream_buffer #(.DATA_W(DW), .DEPTH(8), .CHANNELS(3), .DROP_OLDEST(0), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .clear(clear && (sel == 2'd0)), .bus(if_a),
    .level(lvl_a), .full(full_a), .empty(empty_a), .drop_cnt(drop_a), .bad_chan(bad_a));
  stim_stream_buffer #(.DATA_W(DW), .DEPTH(4), .CHANNELS(1), .DROP_OLDEST(0), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .clear(clear && (sel == 2'd1)), .bus(if_b),
    .level(lvl_b), .full(full_b), .empty(empty_b), .drop_cnt(drop_b), .bad_chan(bad_b));
  stim_stream_buffer #(.DATA_W(DW), .DEPTH(4), .CHANNELS(1), .DROP_OLDEST(1), .CNT_W(4)) u_c (
    .clk(clk), .rst(rst), .clear(clear && (sel == 2'd2)), .bus(if_c),
    .level(lvl_c), .full(full_c), .empty(empty_c), .drop_cnt(drop_c), .bad_chan(bad_c));

  // Outputs of the selected instance, widened to common widths.
  logic                 o_valid, o_in_ready, o_full, o_empty, o_bad;
  logic signed [DW-1:0] o_data;
  logic [1:0]           o_chan;
  logic [15:0]          o_seq, o_drop;
  logic [3:0]           o_level;

  always_comb begin
    o_valid    = if_a.out_valid;
    o_in_ready = if_a.in_ready;
    o_data     = if_a.out_data;
    o_chan     = if_a.out_chan;
    o_seq      = if_a.out_seq;
    o_level    = lvl_a;
    o_full     = full_a;
    o_empty    = empty_a;
    o_drop     = drop_a;
    o_bad      = bad_a;
    if (sel == 2'd1) begin
      o_valid    = if_b.out_valid;
      o_in_ready = if_b.in_ready;
      o_data     = if_b.out_data;
      o_chan     = {1'b0, if_b.out_chan};
      o_seq      = if_b.out_seq;
      o_level    = {1'b0, lvl_b};
      o_full     = full_b;
      o_empty    = empty_b;
      o_drop     = drop_b;
      o_bad      = bad_b;
    end else if (sel == 2'd2) begin
      o_valid    = if_c.out_valid;
      o_in_ready = if_c.in_ready;
      o_data     = if_c.out_data;
      o_chan     = {1'b0, if_c.out_chan};
      o_seq      = {12'b0, if_c.out_seq};
      o_level    = {1'b0, lvl_c};
      o_full     = full_c;
      o_empty    = empty_c;
      o_drop     = {12'b0, drop_c};
      o_bad      = bad_c;
    end
  end

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input int data, input int seq, input int lvl);
    check({tag, ".valid"}, o_valid, (lvl != 0) ? 1 : 0);
    check({tag, ".data"},  o_data, data);
    check({tag, ".seq"},   o_seq, seq);
    check({tag, ".level"}, o_level, lvl);
  endtask

  task automatic drive(input logic v, input int d, input int c, input logic r);
    in_valid  = v;
    in_data   = DW'(d);
    in_chan   = 2'(c);
    out_ready = r;
  endtask

  typedef struct {
    logic rst_v;
    logic in_v;
    logic ordy;
    int   data;
    int   e_valid;
    int   e_data;
    int   e_seq;
    int   e_level;
    int   e_rdy;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    sel = 2'd0; clear = 1'b0; rst = 1'b1;
    drive(1'b0, 0, 0, 1'b0);

    // Reset then fill / drain on A.
    tbl[0]  = '{1, 0, 0, 0,      0, 0,      0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0,      0, 0,      0, 0, 0};
    tbl[2]  = '{0, 1, 0, -3,     1, -3,     0, 1, 1};
    tbl[3]  = '{0, 1, 0, 0,      1, -3,     0, 2, 1};
    tbl[4]  = '{0, 1, 0, 65535,  1, -3,     0, 3, 1};
    tbl[5]  = '{0, 1, 0, -65536, 1, -3,     0, 4, 1};
    tbl[6]  = '{0, 1, 0, 7,      1, -3,     0, 5, 1};
    tbl[7]  = '{0, 0, 1, 0,      1, 0,      1, 4, 1};
    tbl[8]  = '{0, 0, 1, 0,      1, 65535,  2, 3, 1};
    tbl[9]  = '{0, 0, 1, 0,      1, -65536, 3, 2, 1};
    tbl[10] = '{0, 0, 1, 0,      1, 7,      4, 1, 1};
    tbl[11] = '{0, 0, 1, 0,      0, 0,      0, 0, 1};

    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst_v;
      drive(tbl[i].in_v, tbl[i].data, 0, tbl[i].ordy);
      step();
      check($sformatf("vec%0d.valid", i),    o_valid, tbl[i].e_valid);
      check($sformatf("vec%0d.data", i),     o_data, tbl[i].e_data);
      check($sformatf("vec%0d.seq", i),      o_seq, tbl[i].e_seq);
      check($sformatf("vec%0d.level", i),    o_level, tbl[i].e_level);
      check($sformatf("vec%0d.in_ready", i), o_in_ready, tbl[i].e_rdy);
      check($sformatf("vec%0d.empty", i),    o_empty, (tbl[i].e_level == 0) ? 1 : 0);
    end
    drive(1'b0, 0, 0, 1'b0);

    // Backpressure on B.
    sel = 2'd1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i + 1, 0, 1'b0);
      step();
    end
    check("bp.full", o_full, 1);
    check("bp.in_ready", o_in_ready, 0);
    check("bp.drop", o_drop, 0);
    chk_head("bp.fill", 1, 0, 4);
    drive(1'b1, 5, 0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk_head($sformatf("bp.hold%0d", i), 1, 0, 4);
    end
    drive(1'b1, 5, 0, 1'b1);
    step();
    chk_head("bp.pop", 2, 1, 3);
    check("bp.pop.in_ready", o_in_ready, 1);
    drive(1'b1, 5, 0, 1'b0);
    step();
    check("bp.refill.level", o_level, 4);
    check("bp.refill.in_ready", o_in_ready, 0);
    drive(1'b0, 0, 0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk_head($sformatf("bp.drain%0d", k), 2 + k, 1 + k, 4 - k);
      step();
    end
    check("bp.empty", o_empty, 1);

    // Drop-oldest on C.
    sel = 2'd2;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 10 * (i + 1), 0, 1'b0);
      step();
    end
    chk_head("do.window", 30, 2, 4);
    check("do.drop", o_drop, 2);
    check("do.full", o_full, 1);
    check("do.in_ready", o_in_ready, 1);
    drive(1'b1, 70, 0, 1'b1);
    step();
    chk_head("do.pushpop", 40, 3, 4);
    check("do.pushpop.drop", o_drop, 2);
    drive(1'b0, 0, 0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk_head($sformatf("do.drain%0d", k), 40 + 10 * k, 3 + k, 4 - k);
      step();
    end
    check("do.empty", o_empty, 1);

    // Sequence wrap on C (CNT_W=4).
    rst = 1'b1; drive(1'b0, 0, 0, 1'b0);
    step();
    rst = 1'b0;
    check("wrap.reset.drop", o_drop, 0);
    for (int k = 1; k <= 20; k++) begin
      drive(1'b1, k - 1, 0, 1'b1);
      step();
      chk_head($sformatf("wrap%0d", k), k - 1, (k - 1) % 16, 1);
    end
    drive(1'b0, 0, 0, 1'b1);
    step();
    check("wrap.empty", o_empty, 1);

    // drop_cnt saturation on C.
    rst = 1'b1; drive(1'b0, 0, 0, 1'b0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, i, 0, 1'b0);
      step();
      if (i >= 4) check($sformatf("sat.drop%0d", i), o_drop, (i - 3 > 15) ? 15 : i - 3);
    end
    drive(1'b0, 0, 0, 1'b0);
    chk_head("sat.head", 20, 4, 4);

    // Channel tags on A (CHANNELS=3).
    sel = 2'd0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 100 + i, (i == 4) ? 1 : i, 1'b0);
      step();
      check($sformatf("ch.bad%0d", i), o_bad, (i >= 3) ? 1 : 0);
      check($sformatf("ch.level%0d", i), o_level, (i < 3) ? i + 1 : i);
    end
    drive(1'b0, 0, 0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("ch.chan%0d", k), o_chan, (k == 3) ? 1 : k);
      check($sformatf("ch.data%0d", k), o_data, (k == 3) ? 104 : 100 + k);
      check($sformatf("ch.seq%0d", k), o_seq, k);
      step();
    end
    check("ch.empty", o_empty, 1);
    check("ch.bad.sticky", o_bad, 1);

    // clear and rst mid-stream on A.
    rst = 1'b1; drive(1'b0, 0, 0, 1'b0);
    step();
    rst = 1'b0;
    check("clr.bad.reset", o_bad, 0);
    drive(1'b1, 5, 3, 1'b0);
    step();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, i, 0, 1'b0);
      step();
    end
    check("clr.pre.level", o_level, 3);
    check("clr.pre.bad", o_bad, 1);
    clear = 1'b1;
    drive(1'b1, 9, 0, 1'b1);
    step();
    clear = 1'b0;
    drive(1'b0, 0, 0, 1'b0);
    chk_head("clr.post", 0, 0, 0);
    check("clr.post.empty", o_empty, 1);
    check("clr.post.bad", o_bad, 1);
    drive(1'b1, 55, 0, 1'b0);
    step();
    chk_head("clr.next", 55, 3, 1);
    drive(1'b1, 56, 0, 1'b0);
    step();
    check("clr.two.level", o_level, 2);
    rst = 1'b1;
    drive(1'b1, 57, 0, 1'b1);
    step();
    chk_head("rst.mid", 0, 0, 0);
    check("rst.mid.chan", o_chan, 0);
    check("rst.mid.empty", o_empty, 1);
    check("rst.mid.full", o_full, 0);
    check("rst.mid.in_ready", o_in_ready, 0);
    check("rst.mid.bad", o_bad, 0);
    check("rst.mid.drop", o_drop, 0);
    rst = 1'b0;
    #1;
    check("rst.rel.in_ready", o_in_ready, 1);
    drive(1'b1, 77, 0, 1'b0);
    step();
    chk_head("rst.next", 77, 0, 1);
    drive(1'b0, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
